// File: rtl/sva_result_monitor.sv
// ---------------------------------------------------------------------------
// sva_result_monitor
//
// Collects the result pulses of an assertion checker: counts successes,
// failures and (optionally) lazy successes, keeps an overall verdict, and
// logs the timestamp of every failure in a small FIFO that a consumer drains
// with a valid/ready handshake.
//
// Configuration macro: SVA_MON_LAZY_EN
//   defined   - lazy_succ is counted in lazy_cnt and moves IDLE -> PASSING
//   undefined - lazy_succ is ignored and lazy_cnt reads 0
//
// Parameters
//   CNT_W    width of each saturating event counter
//   STAMP_W  width of a failure timestamp
//   DEPTH    failure log entries (power of two, >= 2)
//
// Ports
//   sys_clk    in   system clock (single domain)
//   sys_rst    in   asynchronous active-high reset
//   clr        in   synchronous clear of counters, verdict, log, overflow
//   succ       in   checker success pulse
//   fail       in   checker failure pulse
//   lazy_succ  in   checker lazy-success pulse
//   stamp      in   evaluation timestamp, logged with fail
//   succ_cnt   out  success count
//   fail_cnt   out  failure count
//   lazy_cnt   out  lazy-success count
//   verdict    out  0=IDLE, 1=PASSING, 2=FAILED
//   log_valid  out  log head entry available
//   log_ready  in   consumer accepts the head entry
//   log_data   out  timestamp at the log head
//   log_ovf    out  sticky: a failure timestamp was dropped
// ---------------------------------------------------------------------------
module sva_result_monitor #(
  parameter int CNT_W   = 16,
  parameter int STAMP_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               clr,
  input  logic               succ,
  input  logic               fail,
  input  logic               lazy_succ,
  input  logic [STAMP_W-1:0] stamp,
  output logic [CNT_W-1:0]   succ_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   lazy_cnt,
  output logic [1:0]         verdict,
  output logic               log_valid,
  input  logic               log_ready,
  output logic [STAMP_W-1:0] log_data,
  output logic               log_ovf
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = AW + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASSING = 2'd1,
    ST_FAILED  = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [CNT_W-1:0]   succ_cnt_r;
  logic [CNT_W-1:0]   fail_cnt_r;
  logic [STAMP_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]   occ_r;
  logic               ovf_r;

  logic lazy_ev_s;
  logic full_s;
  logic empty_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

`ifdef SVA_MON_LAZY_EN
  logic [CNT_W-1:0] lazy_cnt_r;

  assign lazy_ev_s = lazy_succ;

  // Saturating lazy-success counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lazy_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      lazy_cnt_r <= {CNT_W{1'b0}};
    end else if (lazy_succ && (lazy_cnt_r != CNT_MAX)) begin
      lazy_cnt_r <= lazy_cnt_r + CNT_W'(1);
    end
  end

  assign lazy_cnt = lazy_cnt_r;
`else
  logic unused_lazy_s;

  assign unused_lazy_s = lazy_succ;
  assign lazy_ev_s     = 1'b0;
  assign lazy_cnt      = {CNT_W{1'b0}};
`endif

  // FIFO status and handshake; clr discards everything in its cycle
  always_comb begin
    empty_s = (occ_r == {OCC_W{1'b0}});
    full_s  = (occ_r == FULL_OCC);
    pop_s   = 1'b0;
    push_s  = 1'b0;
    drop_s  = 1'b0;
    if (!clr) begin
      pop_s  = !empty_s && log_ready;
      // A pop in the same cycle frees the slot a full FIFO needs
      push_s = fail && (!full_s || pop_s);
      drop_s = fail && full_s && !pop_s;
    end else begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // Saturating success and failure counters
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      succ_cnt_r <= {CNT_W{1'b0}};
      fail_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      succ_cnt_r <= {CNT_W{1'b0}};
      fail_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (succ && (succ_cnt_r != CNT_MAX)) begin
        succ_cnt_r <= succ_cnt_r + CNT_W'(1);
      end
      if (fail && (fail_cnt_r != CNT_MAX)) begin
        fail_cnt_r <= fail_cnt_r + CNT_W'(1);
      end
    end
  end

  // Verdict state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Verdict next-state logic; clr has priority over every event
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fail) begin
            state_nxt_s = ST_FAILED;
          end else if (succ || lazy_ev_s) begin
            state_nxt_s = ST_PASSING;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PASSING: begin
          if (fail) begin
            state_nxt_s = ST_FAILED;
          end else begin
            state_nxt_s = ST_PASSING;
          end
        end
        ST_FAILED: state_nxt_s = ST_FAILED;
        ST_BAD:    state_nxt_s = ST_IDLE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Failure log storage; cleared so an empty log reads 0 after reset or clr.
  // A full FIFO only accepts a push together with a pop, so the head entry
  // is never overwritten while it is still being offered.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {STAMP_W{1'b0}};
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {STAMP_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= stamp;
    end
  end

  // Log pointers, occupancy and sticky overflow flag; pointers wrap mod DEPTH
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
      ovf_r    <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign succ_cnt  = succ_cnt_r;
  assign fail_cnt  = fail_cnt_r;
  assign verdict   = state_r;
  assign log_valid = !empty_s;
  assign log_data  = mem_r[rd_ptr_r];
  assign log_ovf   = ovf_r;

endmodule

// File: tb/tb_sva_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_sva_result_monitor
//
// Self-checking bench for sva_result_monitor (CNT_W=4, STAMP_W=8, DEPTH=4).
// A reference model tracks counters, verdict and overflow; expected failure
// timestamps are queued when a fail is driven and popped/compared when the
// DUT hands the head entry over. Honours SVA_MON_LAZY_EN like the design.
// ---------------------------------------------------------------------------
module tb_sva_result_monitor;

  localparam int CNT_W   = 4;
  localparam int STAMP_W = 8;
  localparam int DEPTH   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               clr = 1'b0;
  logic               succ = 1'b0;
  logic               fail = 1'b0;
  logic               lazy_succ = 1'b0;
  logic [STAMP_W-1:0] stamp = 8'h00;
  logic               log_ready = 1'b0;
  logic [CNT_W-1:0]   succ_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic [CNT_W-1:0]   lazy_cnt;
  logic [1:0]         verdict;
  logic               log_valid;
  logic [STAMP_W-1:0] log_data;
  logic               log_ovf;

  sva_result_monitor #(
    .CNT_W  (CNT_W),
    .STAMP_W(STAMP_W),
    .DEPTH  (DEPTH)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .clr      (clr),
    .succ     (succ),
    .fail     (fail),
    .lazy_succ(lazy_succ),
    .stamp    (stamp),
    .succ_cnt (succ_cnt),
    .fail_cnt (fail_cnt),
    .lazy_cnt (lazy_cnt),
    .verdict  (verdict),
    .log_valid(log_valid),
    .log_ready(log_ready),
    .log_data (log_data),
    .log_ovf  (log_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec  = 0;
  int n_miss = 0;

  int m_succ, m_fail, m_lazy, m_verdict, m_ovf;
  bit m_fresh;
  logic [STAMP_W-1:0] m_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_succ = 0; m_fail = 0; m_lazy = 0; m_verdict = 0; m_ovf = 0;
    m_q.delete();
    m_fresh = 1'b1;
  endtask

  task automatic check_all();
    check_val("succ_cnt", 32'(succ_cnt), 32'(m_succ));
    check_val("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    check_val("lazy_cnt", 32'(lazy_cnt), 32'(m_lazy));
    check_val("verdict", 32'(verdict), 32'(m_verdict));
    check_val("log_valid", 32'(log_valid), 32'(m_q.size() != 0));
    check_val("log_ovf", 32'(log_ovf), 32'(m_ovf));
    if (m_q.size() != 0) begin
      check_val("log_head", 32'(log_data), 32'(m_q[0]));
    end else if (m_fresh) begin
      check_val("log_empty_data", 32'(log_data), 32'd0);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge
  task automatic step(input bit s, input bit f, input bit l, input logic [7:0] st,
                      input bit rdy, input bit c);
    bit lz;
    bit pop;
    bit full;
    succ = s; fail = f; lazy_succ = l; stamp = st; log_ready = rdy; clr = c;
`ifdef SVA_MON_LAZY_EN
    lz = l;
`else
    lz = 1'b0;
`endif
    if (c) begin
      model_reset();
    end else begin
      pop  = (m_q.size() != 0) && rdy;
      full = (m_q.size() == DEPTH);
      if (pop) begin
        check_val("pop_data", 32'(log_data), 32'(m_q[0]));
        void'(m_q.pop_front());
      end
      if (f) begin
        if (!full || pop) begin
          m_q.push_back(st);
          m_fresh = 1'b0;
        end else begin
          m_ovf = 1;
        end
      end
      if (s && m_succ < CMAX) m_succ++;
      if (f && m_fail < CMAX) m_fail++;
      if (lz && m_lazy < CMAX) m_lazy++;
      if (m_verdict == 0) begin
        if (f) m_verdict = 2;
        else if (s || lz) m_verdict = 1;
      end else if (m_verdict == 1) begin
        if (f) m_verdict = 2;
      end
    end
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_all();                      // reset state
    sys_rst = 1'b0;

    // Three successes -> PASSING, nothing logged
    repeat (3) step(1, 0, 0, 8'h00, 0, 0);
    check_val("req19_succ", 32'(succ_cnt), 32'd3);

    // One failure held at the head until accepted
    step(0, 1, 0, 8'h2A, 0, 0);
    repeat (3) step(0, 0, 0, 8'h00, 0, 0);
    check_val("req20_data", 32'(log_data), 32'h2A);
    step(0, 0, 0, 8'h00, 1, 0);
    check_val("req20_valid", 32'(log_valid), 32'd0);

    // Five failures into a four-deep log -> overflow, in-order readback
    step(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h10 + 8'(i), 0, 0);
    check_val("req21_ovf", 32'(log_ovf), 32'd1);
    repeat (5) step(0, 0, 0, 8'h00, 1, 0);

    // Full log with a pop in the same cycle: push accepted, no overflow
    step(0, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h40 + 8'(i), 0, 0);
    step(0, 1, 0, 8'h77, 1, 0);
    check_val("req12_ovf", 32'(log_ovf), 32'd0);
    repeat (5) step(0, 0, 0, 8'h00, 1, 0);

    // succ and fail together
    step(0, 0, 0, 8'h00, 0, 1);
    step(1, 1, 0, 8'h5C, 0, 0);
    check_val("req22_verdict", 32'(verdict), 32'd2);

    // Saturation, then clear
    step(0, 0, 0, 8'h00, 0, 1);
    repeat (17) step(1, 0, 0, 8'h00, 0, 0);
    check_val("req23_sat", 32'(succ_cnt), 32'd15);
    step(1, 1, 1, 8'h99, 1, 1);        // events coinciding with clr are discarded

    // Lazy success
    step(0, 0, 1, 8'h00, 0, 0);

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 40) == 0));
    end

    // Reset mid-operation: immediate clear, then normal sampling
    step(0, 0, 0, 8'h00, 0, 1);
    step(1, 1, 0, 8'hA1, 0, 0);
    step(0, 1, 0, 8'hA2, 0, 0);
    #1 sys_rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    check_all();
    step(0, 1, 0, 8'h3C, 0, 0);
    step(0, 0, 0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
